// File: rtl/softusb_navre_pkg.sv
// Shared definitions for the softusb_navre boot/run controller.
//
// Contents:
//   state_e        - controller state encoding (IDLE..ERROR), 3 bits
//   PMEM_AW_DEF    - default program memory address width
//   HALT_ADDR_DEF  - default IO address of the end-of-test write
//   HALT_DATA_DEF  - default IO data value of the end-of-test write
//   can_start()    - states in which a host start pulse begins a load
package softusb_navre_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4,
    ST_TIMEOUT = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  localparam int         PMEM_AW_DEF   = 10;
  localparam logic [5:0] HALT_ADDR_DEF = 6'h00;
  localparam logic [7:0] HALT_DATA_DEF = 8'hFE;

  // A new load is only allowed when the core is not running and no load is
  // in progress; every "resting" state counts.
  function automatic logic can_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_HALT) || (s == ST_TIMEOUT) ||
           (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/softusb_navre_pmem.sv
// Program memory for the navre core: 2**AW x 16 synchronous RAM with one
// write port (loader) and one read port (core fetch).
//
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset; clears only the read register
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata updates one cycle later, holds otherwise
//   raddr  - read address
//   rdata  - registered read data
module softusb_navre_pmem
  import softusb_navre_pkg::*;
#(
  parameter int AW = PMEM_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];
  logic [15:0] rdata_q;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the array gives old data on a same-address
  // read-during-write.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/softusb_navre_ctrl.sv
// Boot and run controller for the softusb_navre AVR core. Loads program
// memory from a host word stream while summing the words, checks the sum
// against the host checksum, releases the core, and stops it on the halt
// IO write or on a cycle-limit watchdog. Status is sticky until restart.
//
// Ports:
//   sys_clk, sys_rst        - clock, synchronous active-high reset
//   start, abort            - host control pulses (abort has priority)
//   ld_valid/ld_ready       - load word handshake
//   ld_data, ld_last        - program word and end-of-image marker
//   ld_csum                 - expected checksum, taken on the last transfer
//   core_rst                - core reset, low only in RUN
//   pmem_ce, pmem_a, pmem_d - core fetch port, 1-cycle latency
//   io_we, io_a, io_do      - core IO write bus, watched for the halt write
//   state, cycles, words    - status: state code, RUN cycles, words loaded
module softusb_navre_ctrl
  import softusb_navre_pkg::*;
#(
  parameter int         PMEM_AW     = PMEM_AW_DEF,
  parameter int         CYCLE_LIMIT = 1000,
  parameter logic [5:0] HALT_ADDR   = HALT_ADDR_DEF,
  parameter logic [7:0] HALT_DATA   = HALT_DATA_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [15:0]        ld_data,
  input  logic               ld_last,
  input  logic [15:0]        ld_csum,
  output logic               core_rst,
  input  logic               pmem_ce,
  input  logic [PMEM_AW-1:0] pmem_a,
  output logic [15:0]        pmem_d,
  input  logic               io_we,
  input  logic [5:0]         io_a,
  input  logic [7:0]         io_do,
  output logic [2:0]         state,
  output logic [15:0]        cycles,
  output logic [PMEM_AW:0]   words
);

  localparam logic [PMEM_AW-1:0] WPTR_MAX  = '1;
  localparam logic [15:0]        CYC_LAST  = 16'(CYCLE_LIMIT - 1);

  state_e             state_q, state_d;
  logic               core_rst_q, core_rst_d;
  logic               ld_ready_q, ld_ready_d;
  logic [15:0]        cycles_q, cycles_d;
  logic [PMEM_AW:0]   words_q, words_d;
  logic [PMEM_AW-1:0] wptr_q, wptr_d;
  logic [15:0]        sum_q, sum_d;
  logic [15:0]        csum_q, csum_d;

  logic xfer;
  logic halt_hit;

  // Next-state logic. The datapath (write pointer, running sum, counters)
  // is updated first, then the state decision, and abort is applied last
  // so it overrides every other transition. core_rst and ld_ready are
  // derived from the next state so they are registered yet line up exactly
  // with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    words_d  = words_q;
    wptr_d   = wptr_q;
    sum_d    = sum_q;
    csum_d   = csum_q;

    xfer     = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
    halt_hit = io_we && (io_a == HALT_ADDR) && (io_do == HALT_DATA);

    if (xfer) begin
      sum_d   = sum_q + ld_data;
      words_d = words_q + (PMEM_AW+1)'(1);
      // The pointer parks on the last address; that transfer ends the load.
      if (wptr_q != WPTR_MAX) wptr_d = wptr_q + PMEM_AW'(1);
    end

    if (state_q == ST_RUN) cycles_d = cycles_q + 16'd1;

    unique case (state_q)
      ST_LOAD: begin
        if (xfer && (ld_last || (wptr_q == WPTR_MAX))) begin
          csum_d  = ld_csum;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = (sum_q == csum_q) ? ST_RUN : ST_ERROR;
      end
      ST_RUN: begin
        // Halt is tested first so it wins over a timeout on the same cycle.
        if (halt_hit)                   state_d = ST_HALT;
        else if (cycles_q == CYC_LAST)  state_d = ST_TIMEOUT;
      end
      ST_IDLE, ST_HALT, ST_TIMEOUT, ST_ERROR: begin
        state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (can_start(state_q) && start) begin
      state_d  = ST_LOAD;
      wptr_d   = '0;
      sum_d    = '0;
      words_d  = '0;
      cycles_d = '0;
    end

    if (abort) state_d = ST_IDLE;

    core_rst_d = (state_d != ST_RUN);
    ld_ready_d = (state_d == ST_LOAD);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      core_rst_q <= 1'b1;
      ld_ready_q <= 1'b0;
      cycles_q   <= '0;
      words_q    <= '0;
      wptr_q     <= '0;
      sum_q      <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      ld_ready_q <= ld_ready_d;
      cycles_q   <= cycles_d;
      words_q    <= words_d;
      wptr_q     <= wptr_d;
      sum_q      <= sum_d;
      csum_q     <= csum_d;
    end
  end

  softusb_navre_pmem #(
    .AW (PMEM_AW)
  ) u_pmem (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .we    (xfer),
    .waddr (wptr_q),
    .wdata (ld_data),
    .re    (pmem_ce),
    .raddr (pmem_a),
    .rdata (pmem_d)
  );

  assign state    = state_q;
  assign core_rst = core_rst_q;
  assign ld_ready = ld_ready_q;
  assign cycles   = cycles_q;
  assign words    = words_q;

endmodule
